// File: rtl/uram_rd_arbiter_if.sv
// Read-port bundle shared by the two requesters, the arbiter
// and the URAM read port (addr_b / dout_b side).
interface uram_rd_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
);
   logic                  rd0_req;
   logic [ADDR_WIDTH-1:0] rd0_addr;
   logic                  rd0_gnt;
   logic                  rd0_rsp_vld;
   logic [DATA_WIDTH-1:0] rd0_rsp_data;

   logic                  rd1_req;
   logic [ADDR_WIDTH-1:0] rd1_addr;
   logic                  rd1_gnt;
   logic                  rd1_rsp_vld;
   logic [DATA_WIDTH-1:0] rd1_rsp_data;

   logic                  mem_addr_vld;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_dout_vld;
   logic [DATA_WIDTH-1:0] mem_dout;

   logic                  err_orphan;
   logic                  err_missing;

   modport slave (
      input  rd0_req,
      input  rd0_addr,
      output rd0_gnt,
      output rd0_rsp_vld,
      output rd0_rsp_data,
      input  rd1_req,
      input  rd1_addr,
      output rd1_gnt,
      output rd1_rsp_vld,
      output rd1_rsp_data,
      output mem_addr_vld,
      output mem_addr,
      input  mem_dout_vld,
      input  mem_dout,
      output err_orphan,
      output err_missing
   );

   modport master (
      output rd0_req,
      output rd0_addr,
      input  rd0_gnt,
      input  rd0_rsp_vld,
      input  rd0_rsp_data,
      output rd1_req,
      output rd1_addr,
      input  rd1_gnt,
      input  rd1_rsp_vld,
      input  rd1_rsp_data,
      input  mem_addr_vld,
      input  mem_addr,
      output mem_dout_vld,
      output mem_dout,
      input  err_orphan,
      input  err_missing
   );
endinterface

// File: rtl/uram_rd_arbiter.sv
// Round-robin sharing of one URAM read port between two requesters,
// with an ID tag pipe that steers returned words and checks the stream.
module uram_rd_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int RD_LATENCY = 3
) (
   input logic              clk,
   input logic              rst_n,
   uram_rd_arbiter_if.slave bus
);

   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   localparam int BW = $clog2(RD_LATENCY + 2);
   localparam logic [BW-1:0] BLANK_INIT = BW'(RD_LATENCY + 1);

   logic                  last_id_q;
   logic                  gnt0;
   logic                  gnt1;
   logic                  gnt_any;
   logic                  both;
   logic                  only0;
   logic                  only1;

   logic                  iss_vld_q;
   logic                  iss_id_q;
   logic [ADDR_WIDTH-1:0] iss_addr_q;

   tag_t                  tag_q [RD_LATENCY];
   tag_t                  slot;

   logic [BW-1:0]         blank_q;
   logic                  blanking;
   logic                  dout_ok;
   logic                  deliver;
   logic                  orphan;
   logic                  missing;

   logic                  rd0_vld_q;
   logic                  rd1_vld_q;
   logic [DATA_WIDTH-1:0] rd0_data_q;
   logic [DATA_WIDTH-1:0] rd1_data_q;
   logic                  err_orphan_q;
   logic                  err_missing_q;

   assign both  = bus.rd0_req & bus.rd1_req;
   assign only0 = bus.rd0_req & ~bus.rd1_req;
   assign only1 = ~bus.rd0_req & bus.rd1_req;

   // On contention the requester not granted last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (1'b1)
         both: begin
            gnt0 = last_id_q;
            gnt1 = ~last_id_q;
         end
         only0:   gnt0 = 1'b1;
         only1:   gnt1 = 1'b1;
         default: ;
      endcase
   end

   assign gnt_any = gnt0 | gnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_id_q <= 1'b1;
      end else if (gnt_any) begin
         last_id_q <= gnt1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_vld_q  <= 1'b0;
         iss_id_q   <= 1'b0;
         iss_addr_q <= '0;
      end else begin
         iss_vld_q <= gnt_any;
         if (gnt_any) begin
            iss_id_q   <= gnt1;
            iss_addr_q <= gnt1 ? bus.rd1_addr : bus.rd0_addr;
         end
      end
   end

   // Slot leaving the pipe lines up with the RAM return of the same read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= '{vld: iss_vld_q, id: iss_id_q};
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign slot = tag_q[RD_LATENCY-1];

   // Returns of reads issued before reset can still arrive while blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= BLANK_INIT;
      end else if (blank_q != '0) begin
         blank_q <= blank_q - 1'b1;
      end
   end

   assign blanking = (blank_q != '0);
   assign dout_ok  = bus.mem_dout_vld & ~blanking;
   assign deliver  = slot.vld & dout_ok;
   assign orphan   = dout_ok & ~slot.vld;
   assign missing  = slot.vld & ~bus.mem_dout_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd0_vld_q     <= 1'b0;
         rd1_vld_q     <= 1'b0;
         rd0_data_q    <= '0;
         rd1_data_q    <= '0;
         err_orphan_q  <= 1'b0;
         err_missing_q <= 1'b0;
      end else begin
         rd0_vld_q <= deliver & ~slot.id;
         rd1_vld_q <= deliver & slot.id;
         if (deliver & ~slot.id) begin
            rd0_data_q <= bus.mem_dout;
         end
         if (deliver & slot.id) begin
            rd1_data_q <= bus.mem_dout;
         end
         if (orphan) begin
            err_orphan_q <= 1'b1;
         end
         if (missing) begin
            err_missing_q <= 1'b1;
         end
      end
   end

   assign bus.rd0_gnt      = gnt0;
   assign bus.rd1_gnt      = gnt1;
   assign bus.rd0_rsp_vld  = rd0_vld_q;
   assign bus.rd1_rsp_vld  = rd1_vld_q;
   assign bus.rd0_rsp_data = rd0_data_q;
   assign bus.rd1_rsp_data = rd1_data_q;
   assign bus.mem_addr_vld = iss_vld_q;
   assign bus.mem_addr     = iss_addr_q;
   assign bus.err_orphan   = err_orphan_q;
   assign bus.err_missing  = err_missing_q;

endmodule

// File: tb/tb_uram_rd_arbiter.sv
// Bench for uram_rd_arbiter: URAM model, cycle-indexed scoreboard,
// arbitration table and hand-written corner-case sequences.
module tb_uram_rd_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 14;
   localparam int LAT = 3;
   localparam int INF = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   uram_rd_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   uram_rd_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RD_LATENCY(LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      bit            id;
      logic [DW-1:0] d;
   } rsp_t;

   typedef struct {
      bit r0;
      bit r1;
      bit g0;
      bit g1;
   } tv_t;

   logic [DW-1:0] tmem [0:(1<<AW)-1];
   int            cyc = 0;
   int            nvec = 0;
   int            nerr = 0;

   bit            last = 1'b1;
   rsp_t          exp_rsp [int];
   logic [AW-1:0] exp_iss [int];
   logic [DW-1:0] hold0 = '0;
   logic [DW-1:0] hold1 = '0;
   int            orph_from = INF;
   int            miss_from = INF;
   bit            drop_next = 1'b0;
   int            drop_cyc = -1;
   int            inj_cyc = -1;
   logic [DW-1:0] ret [int];
   logic [DW-1:0] log1 [$];
   bit            log1_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endfunction

   // Reference model and RAM model, evaluated mid-cycle.
   always @(negedge clk) begin : model
      rsp_t          e;
      bit            g0;
      bit            g1;
      bit            v0;
      bit            v1;
      logic [AW-1:0] a;
      if (!rst_n) begin
         last      = 1'b1;
         exp_rsp.delete();
         exp_iss.delete();
         hold0     = '0;
         hold1     = '0;
         orph_from = INF;
         miss_from = INF;
      end
      g0 = 1'b0;
      g1 = 1'b0;
      if (bus.rd0_req && bus.rd1_req) begin
         if (last) g0 = 1'b1;
         else g1 = 1'b1;
      end else if (bus.rd0_req) begin
         g0 = 1'b1;
      end else if (bus.rd1_req) begin
         g1 = 1'b1;
      end
      chk("rd0_gnt", bus.rd0_gnt, g0);
      chk("rd1_gnt", bus.rd1_gnt, g1);
      if (rst_n && (g0 || g1)) begin
         a    = g1 ? bus.rd1_addr : bus.rd0_addr;
         last = g1;
         exp_iss[cyc+1] = a;
         if (drop_next) begin
            drop_next = 1'b0;
            drop_cyc  = cyc + 1;
            if (miss_from == INF) miss_from = cyc + LAT + 2;
         end else begin
            exp_rsp[cyc+LAT+2] = '{id: g1, d: tmem[a]};
         end
      end
      chk("mem_addr_vld", bus.mem_addr_vld, exp_iss.exists(cyc) ? 1 : 0);
      if (exp_iss.exists(cyc)) begin
         chk("mem_addr", bus.mem_addr, exp_iss[cyc]);
         exp_iss.delete(cyc);
      end
      v0 = 1'b0;
      v1 = 1'b0;
      if (exp_rsp.exists(cyc)) begin
         e = exp_rsp[cyc];
         exp_rsp.delete(cyc);
         if (e.id) begin
            v1    = 1'b1;
            hold1 = e.d;
         end else begin
            v0    = 1'b1;
            hold0 = e.d;
         end
      end
      chk("rd0_rsp_vld", bus.rd0_rsp_vld, v0);
      chk("rd1_rsp_vld", bus.rd1_rsp_vld, v1);
      chk("rd0_rsp_data", bus.rd0_rsp_data, hold0);
      chk("rd1_rsp_data", bus.rd1_rsp_data, hold1);
      chk("err_orphan", bus.err_orphan, (cyc >= orph_from) ? 1 : 0);
      chk("err_missing", bus.err_missing, (cyc >= miss_from) ? 1 : 0);
      if (log1_en && bus.rd1_rsp_vld) log1.push_back(bus.rd1_rsp_data);
      if (bus.mem_addr_vld && cyc != drop_cyc) ret[cyc+LAT] = tmem[bus.mem_addr];
      if (ret.exists(cyc)) begin
         bus.mem_dout_vld = 1'b1;
         bus.mem_dout     = ret[cyc];
         ret.delete(cyc);
      end else if (cyc == inj_cyc) begin
         bus.mem_dout_vld = 1'b1;
         bus.mem_dout     = 32'hBAD0_0BAD;
      end else begin
         bus.mem_dout_vld = 1'b0;
         bus.mem_dout     = '0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r0, input int a0, input bit r1, input int a1);
      bus.rd0_req  = r0;
      bus.rd0_addr = AW'(a0);
      bus.rd1_req  = r1;
      bus.rd1_addr = AW'(a1);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (LAT + 2) tick();
   endtask

   tv_t tv [14];
   int  t0;
   int  a0;
   int  a1;
   bit  r0;
   bit  r1;

   initial begin
      tv[0]  = '{1, 1, 1, 0};
      tv[1]  = '{1, 1, 0, 1};
      tv[2]  = '{1, 1, 1, 0};
      tv[3]  = '{1, 1, 0, 1};
      tv[4]  = '{1, 1, 1, 0};
      tv[5]  = '{1, 1, 0, 1};
      tv[6]  = '{0, 0, 0, 0};
      tv[7]  = '{0, 1, 0, 1};
      tv[8]  = '{1, 1, 1, 0};
      tv[9]  = '{0, 0, 0, 0};
      tv[10] = '{1, 1, 0, 1};
      tv[11] = '{1, 0, 1, 0};
      tv[12] = '{0, 1, 0, 1};
      tv[13] = '{1, 1, 1, 0};

      for (int i = 0; i < (1 << AW); i++) begin
         tmem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
      end
      tmem[16'h0010] = 32'hA5A5_0001;
      bus.mem_dout_vld = 1'b0;
      bus.mem_dout     = '0;
      drive(0, 0, 0, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (LAT + 2) tick();

      // single read, fixed latency
      t0 = cyc;
      drive(1, 'h10, 0, 0);
      @(negedge clk);
      chk("t1_gnt", bus.rd0_gnt, 1);
      tick();
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("t1_issue_vld", bus.mem_addr_vld, 1);
      chk("t1_issue_addr", bus.mem_addr, 'h10);
      repeat (4) tick();
      @(negedge clk);
      chk("t1_cycle", cyc - t0, 5);
      chk("t1_rsp_vld", bus.rd0_rsp_vld, 1);
      chk("t1_rsp_data", bus.rd0_rsp_data, 32'hA5A5_0001);
      chk("t1_other_vld", bus.rd1_rsp_vld, 0);
      tick();

      // arbitration table from a freshly reset pointer
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(tv[i].r0, 1, tv[i].r1, 2);
         @(negedge clk);
         chk("tbl_gnt0", bus.rd0_gnt, tv[i].g0);
         chk("tbl_gnt1", bus.rd1_gnt, tv[i].g1);
         tick();
      end
      drive(0, 0, 0, 0);
      repeat (8) tick();

      // single requester streaming
      log1.delete();
      log1_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, i);
         tick();
      end
      drive(0, 0, 0, 0);
      repeat (8) tick();
      log1_en = 1'b0;
      chk("t3_count", log1.size(), 8);
      if (log1.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("t3_data", log1[i], tmem[i]);
      end

      // random traffic; requesters hold until granted
      r0 = 0;
      r1 = 0;
      a0 = 0;
      a1 = 0;
      for (int i = 0; i < 400; i++) begin
         drive(r0, a0, r1, a1);
         @(negedge clk);
         if (!(r0 && !bus.rd0_gnt)) begin
            r0 = ($urandom_range(0, 3) != 0);
            a0 = $urandom_range(0, 255);
         end
         if (!(r1 && !bus.rd1_gnt)) begin
            r1 = ($urandom_range(0, 2) != 0);
            a1 = $urandom_range(0, 255);
         end
         tick();
      end
      drive(0, 0, 0, 0);
      repeat (8) tick();

      // one return suppressed by the RAM
      drop_next = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 'h20 + i, 1, 'h40 + i);
         tick();
      end
      drive(0, 0, 0, 0);
      repeat (8) tick();

      // orphan return on an empty tag pipe
      inj_cyc   = cyc + 2;
      orph_from = cyc + 3;
      repeat (6) tick();

      // reset with reads in flight
      for (int i = 0; i < 4; i++) begin
         drive(1, 'h30 + i, 1, 'h50 + i);
         tick();
      end
      drive(0, 0, 0, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();

      for (int i = 0; i < 100; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 255),
               $urandom_range(0, 1), $urandom_range(0, 255));
         tick();
      end
      drive(0, 0, 0, 0);
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
